// File: rtl/bcd_updown_counter_if.sv
// Control, load data and count/flag bundle of the BCD up/down counter.
// The master drives the controls and load value; the slave returns the count and flags.
interface bcd_updown_counter_if #(
  parameter int NDIGITS = 4,
  parameter int TOP_MOD = 10
);
  logic                   load;
  logic                   counter_on;
  logic                   count_up;
  logic                   saturate;
  logic [4*NDIGITS-1:0]   Data_in;
  logic [4*NDIGITS-1:0]   Count;
  logic                   carry_out;
  logic                   load_err;
  logic                   at_max;
  logic                   at_zero;

  modport master (
    output load, counter_on, count_up, saturate, Data_in,
    input  Count, carry_out, load_err, at_max, at_zero
  );

  modport slave (
    input  load, counter_on, count_up, saturate, Data_in,
    output Count, carry_out, load_err, at_max, at_zero
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// NDIGITS-decade BCD up/down counter with a TOP_MOD top digit, validated load and wrap/saturate limits.
// Count and pulses are registered (1-cycle latency); at_max/at_zero decode Count combinationally.
module bcd_updown_counter #(
  parameter int NDIGITS = 4,
  parameter int TOP_MOD = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_updown_counter_if.slave   bus
);
  localparam int W = 4 * NDIGITS;

  logic [W-1:0] r_count;
  logic         r_carry;
  logic         r_load_err;

  logic [W-1:0] w_next;
  logic [W-1:0] w_max;
  logic         w_load_ok;
  logic         w_wrap;

  always_comb begin
    logic       chain;
    logic [3:0] dig;
    logic [3:0] lim;
    logic [3:0] ld;
    w_next    = r_count;
    w_max     = '0;
    w_load_ok = 1'b1;
    chain     = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      dig = r_count[4*i +: 4];
      ld  = bus.Data_in[4*i +: 4];
      lim = (i == NDIGITS - 1) ? 4'(TOP_MOD - 1) : 4'd9;
      w_max[4*i +: 4] = lim;
      if (ld > lim)
        w_load_ok = 1'b0;
      // A digit steps only when every lower digit sits at its rollover value.
      if (chain) begin
        if (bus.count_up)
          w_next[4*i +: 4] = (dig == lim) ? 4'd0 : dig + 4'd1;
        else
          w_next[4*i +: 4] = (dig == 4'd0) ? lim : dig - 4'd1;
      end
      chain = chain & (bus.count_up ? (dig == lim) : (dig == 4'd0));
    end
  end

  assign bus.at_max  = (r_count == w_max);
  assign bus.at_zero = (r_count == '0);
  assign w_wrap      = bus.count_up ? bus.at_max : bus.at_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else if (bus.load) begin
      r_carry    <= 1'b0;
      r_load_err <= ~w_load_ok;
      if (w_load_ok)
        r_count <= bus.Data_in;
    end else if (bus.counter_on) begin
      r_load_err <= 1'b0;
      r_carry    <= w_wrap & ~bus.saturate;
      if (!(w_wrap && bus.saturate))
        r_count <= w_next;
    end else begin
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign bus.Count     = r_count;
  assign bus.carry_out = r_carry;
  assign bus.load_err  = r_load_err;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for a 2-digit counter with a mod-6 top digit (00..59).
module tb_bcd_updown_counter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bcd_updown_counter_if #(.NDIGITS(2), .TOP_MOD(6)) bus ();

  bcd_updown_counter #(.NDIGITS(2), .TOP_MOD(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [7:0] d,
                       input logic on, input logic up, input logic sat);
    reset          = rst;
    bus.load       = ld;
    bus.Data_in    = d;
    bus.counter_on = on;
    bus.count_up   = up;
    bus.saturate   = sat;
  endtask

  task automatic state(input string tag, input logic [7:0] cnt, input logic cy, input logic le);
    chk({tag, "_count"}, bus.Count, cnt);
    chk({tag, "_carry"}, {7'd0, bus.carry_out}, {7'd0, cy});
    chk({tag, "_lerr"},  {7'd0, bus.load_err},  {7'd0, le});
  endtask

  initial begin
    drive(1, 0, 8'h00, 0, 1, 0); tick();
    state("reset", 8'h00, 0, 0);
    chk("reset_at_zero", {7'd0, bus.at_zero}, 8'd1);
    chk("reset_at_max",  {7'd0, bus.at_max},  8'd0);

    // Count up across a decade boundary and through the top wrap
    drive(0, 1, 8'h08, 0, 1, 0); tick(); state("ld08", 8'h08, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 0); tick(); state("up09", 8'h09, 0, 0);
    tick();                             state("up10", 8'h10, 0, 0);
    drive(0, 1, 8'h58, 0, 1, 0); tick(); state("ld58", 8'h58, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 0); tick(); state("up59", 8'h59, 0, 0);
    chk("at_max_59", {7'd0, bus.at_max}, 8'd1);
    tick();                             state("wrap_up", 8'h00, 1, 0);
    chk("at_max_00", {7'd0, bus.at_max}, 8'd0);
    drive(0, 0, 8'h00, 0, 1, 0); tick(); state("wrap_up_end", 8'h00, 0, 0);

    // Count down across a decade boundary and through zero
    drive(0, 1, 8'h10, 0, 0, 0); tick(); state("ld10", 8'h10, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 0); tick(); state("dn09", 8'h09, 0, 0);
    drive(0, 1, 8'h30, 0, 0, 0); tick();
    drive(0, 0, 8'h00, 1, 0, 0); tick(); state("dn29", 8'h29, 0, 0);
    drive(0, 1, 8'h00, 0, 0, 0); tick(); state("ld00", 8'h00, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 0); tick(); state("wrap_dn", 8'h59, 1, 0);
    drive(0, 0, 8'h00, 0, 0, 0); tick(); state("wrap_dn_end", 8'h59, 0, 0);

    // Saturate mode holds at both limits
    drive(0, 0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); state("sat_up", 8'h59, 0, 0);
    end
    drive(0, 1, 8'h00, 0, 0, 1); tick();
    drive(0, 0, 8'h00, 1, 0, 1); tick(); state("sat_dn", 8'h00, 0, 0);
    chk("sat_dn_at_zero", {7'd0, bus.at_zero}, 8'd1);

    // Load validation
    drive(0, 1, 8'h47, 0, 1, 0); tick(); state("ld47", 8'h47, 0, 0);
    drive(0, 1, 8'h4A, 0, 1, 0); tick(); state("ld4A_rej", 8'h47, 0, 1);
    drive(0, 0, 8'h00, 0, 1, 0); tick(); state("lerr_clear", 8'h47, 0, 0);
    drive(0, 1, 8'h60, 0, 1, 0); tick(); state("ld60_rej", 8'h47, 0, 1);
    drive(0, 0, 8'h00, 0, 1, 0); tick(); state("lerr_clear2", 8'h47, 0, 0);

    // Priority
    drive(0, 1, 8'h23, 1, 1, 0); tick(); state("ld_over_cnt", 8'h23, 0, 0);
    drive(1, 1, 8'h33, 0, 1, 0); tick(); state("rst_over_ld", 8'h00, 0, 0);
    drive(0, 1, 8'h58, 0, 1, 0); tick();
    drive(0, 0, 8'h00, 1, 1, 0); tick(); tick(); state("pre_rst_wrap", 8'h00, 1, 0);
    drive(1, 0, 8'h00, 1, 1, 0); tick(); state("rst_mid_cnt", 8'h00, 0, 0);
    drive(0, 1, 8'h15, 0, 1, 0); tick();
    drive(0, 1, 8'h4A, 0, 1, 0); tick(); state("pre_rst_lerr", 8'h15, 0, 1);
    drive(1, 0, 8'h00, 1, 1, 0); tick(); state("rst_clr_lerr", 8'h00, 0, 0);

    // Hold
    drive(0, 1, 8'h37, 0, 1, 0); tick();
    drive(0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); state("hold", 8'h37, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with synchronous load, per-cycle enable, a selectable wrap or saturate mode, and wrap/terminal-count flags. It generalises the single-digit mod-10 counter to NDIGITS cascaded decades. The most significant digit has a configurable modulus, so the same block serves 0..9999 event counters and 0..59 style timer fields. It sits in the datapath feeding display decoders and timer logic.

## Interface
- NDIGITS, default 4: number of BCD digits, range 1..8.
- TOP_MOD, default 10: modulus of the most significant digit, range 2..10.
  - Maximum count is (TOP_MOD-1) followed by NDIGITS-1 nines.
  - With NDIGITS=2, TOP_MOD=6 the maximum is 59.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load Data_in this cycle, subject to validation.
- counter_on  in  1  count enable.
- count_up  in  1  1 = increment, 0 = decrement; sampled only when counting.
- saturate  in  1  1 = hold at the limits, 0 = wrap around.
- Data_in  in  4*NDIGITS  BCD load value; digit i occupies bits [4i+3:4i].
- Count  out  4*NDIGITS  registered BCD count, same digit packing as Data_in.
- carry_out  out  1  registered one-cycle pulse, high for the cycle after a wrap in either direction.
- load_err  out  1  registered one-cycle pulse, high for the cycle after a rejected load.
- at_max  out  1  combinational; Count equals the maximum.
- at_zero  out  1  combinational; Count equals 0.

## Operation
- Priority per edge: reset > load > counter_on > hold.
- reset: Count=0, carry_out=0, load_err=0.
- Load validation:
  - Valid when every digit is ≤9 and the top digit is ≤TOP_MOD-1.
  - Valid load: Count<=Data_in, load_err<=0.
  - Invalid load: Count unchanged, load_err<=1.
  - Either way carry_out<=0 and no counting occurs that cycle.
- Counting up (counter_on=1, count_up=1):
  - Digit 0 always steps; digit i steps when all lower digits are 9.
  - A stepping digit at 9 (top digit: at TOP_MOD-1) goes to 0; otherwise it increments.
- Counting down (counter_on=1, count_up=0):
  - Digit i steps when all lower digits are 0.
  - A stepping digit at 0 goes to 9 (top digit: to TOP_MOD-1); otherwise it decrements.
- Limits, saturate=0:
  - Up from max gives 0 with carry_out<=1.
  - Down from 0 gives max with carry_out<=1.
- Limits, saturate=1:
  - Up at max and down at 0 hold Count; carry_out<=0.
- carry_out<=0 on every cycle that does not wrap.
- load_err<=0 on every cycle without a rejected load.
- counter_on=0 and load=0: Count holds; both pulses deassert.
- Count never holds a non-BCD digit or a top digit ≥TOP_MOD.

## Timing
- Count, carry_out and load_err are registered; latency is 1 cycle from the sampling edge.
- at_max and at_zero decode Count combinationally, with no added latency.
- Reset values: Count=0, carry_out=0, load_err=0, at_zero=1, at_max=0.
- Reset asserted mid-count takes effect at the next edge and overrides a simultaneous load or count.
- Simultaneous load and counter_on: the load wins; the loaded value is not incremented that cycle.
- Back-to-back wraps, e.g. NDIGITS=1, TOP_MOD=2 counting up continuously, assert carry_out on every wrap cycle.
- No multicycle paths; the ripple-enable across digits completes in one cycle.

## Test plan
All scenarios use NDIGITS=2, TOP_MOD=6.
- Count up: reset, then load 0x08 and count up 2 cycles -> Count 0x09, then 0x10; load 0x58, count up 2 -> 0x59, then 0x00 with carry_out=1 for exactly one cycle; at_max=1 while at 0x59.
- Count down: load 0x10, count down -> 0x09; load 0x00, count down -> 0x59 with carry_out=1; at_zero=1 after reset.
- Saturate: saturate=1 at 0x59 counting up 3 cycles -> stays 0x59, carry_out=0; at 0x00 counting down -> stays 0x00, carry_out=0.
- Load validation: load 0x47 -> 0x47, load_err=0; load 0x4A -> Count stays 0x47, load_err=1 one cycle; load 0x60 -> rejected, load_err=1.
- Priority: load 0x23 with counter_on=1 -> 0x23, not 0x24; reset with load 0x33 -> 0x00; reset asserted mid-count -> 0x00 at next edge, pulses cleared.
- Hold: counter_on=0, load=0 for 5 cycles at 0x37 -> Count stays 0x37, carry_out=0, load_err=0.
